sram_ctrl: RTL and testbench
============================

Name: sram_ctrl

Overview:
- Synchronous front end for the 1024x8 asynchronous SRAM macro (ports en, RWS, addr, data_in, OUT; RWS=1 write, RWS=0 read).
- Converts clocked single-word read/write requests (valid/ready) into correctly sequenced SRAM strobes: setup, access, hold. Captures read data and returns it with a valid pulse.
- Also provides a fill command that writes one value to every location, for memory initialisation.
- Sits directly upstream of the SRAM macro, between it and the system bus.

Parameters:
- AW, 10, address width; depth = 2^AW.
- DW, 8, data width.
- ACC_CYCLES, 2, number of cycles sram_en is held high per access; legal range 1..15.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  controller can accept a request this cycle.
- req_we  in  1  1=write, 0=read.
- req_addr  in  AW  request address.
- req_wdata  in  DW  write data.
- rsp_valid  out  1  one-cycle pulse: rsp_rdata valid (reads only).
- rsp_rdata  out  DW  captured read data.
- fill_start  in  1  start full-memory fill (sampled in IDLE only).
- fill_value  in  DW  fill data, captured with fill_start.
- fill_done  out  1  one-cycle pulse when fill completes.
- busy  out  1  high whenever state != IDLE.
- sram_en  out  1  SRAM enable.
- sram_rws  out  1  SRAM read/write select, 1=write.
- sram_addr  out  AW  SRAM address.
- sram_din  out  DW  SRAM write data.
- sram_dout  in  DW  SRAM read data (macro OUT).

Behaviour:
- Clock is clk. Reset is rst: synchronous, active-high.
- All outputs are registered.
- Reset values: state=IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, fill_done=0, busy=0, sram_en=0, sram_rws=0, sram_addr=0, sram_din=0.
- States: IDLE, SETUP, ACCESS, HOLD, FILL_NEXT.
- IDLE:
  - req_ready=1.
  - fill_start=1 has priority over req_valid. Capture fill_value, set address counter=0, go to SETUP in fill mode; req_ready drops next cycle.
  - Otherwise, on req_valid&&req_ready, latch req_we/req_addr/req_wdata into sram_rws/sram_addr/sram_din and go to SETUP.
- SETUP: one cycle, sram_en=0, addr/data/rws stable; go to ACCESS.
- ACCESS: sram_en=1 for exactly ACC_CYCLES cycles (down-counter). On the last ACCESS cycle of a read, register sram_dout into rsp_rdata. Then go to HOLD.
- HOLD: one cycle, sram_en=0, addr/data/rws unchanged (no address change while en high or at en fall).
  - Single read: rsp_valid=1 this cycle.
  - Single access: next state IDLE; sram_rws returns to 0 on entering IDLE.
  - Fill mode: if addr == 2^AW-1, fill_done=1 this cycle and next state IDLE. Otherwise go to FILL_NEXT.
- FILL_NEXT: sram_addr increments by 1; go to SETUP. No wrap past 2^AW-1; termination uses an explicit terminal compare.
- Latency, request accepted at edge T:
  - SETUP is T+1; ACCESS is T+2..T+1+ACC_CYCLES; HOLD is T+2+ACC_CYCLES.
  - rsp_valid is high in the HOLD cycle.
  - req_ready is high again at T+3+ACC_CYCLES.
  - One access per ACC_CYCLES+3 cycles.
- Writes produce no rsp_valid.
- Fill duration is 2^AW*(ACC_CYCLES+2) + (2^AW-1) cycles from SETUP of address 0 to the fill_done cycle.
- req_valid while req_ready=0 is ignored; the requester must hold it.
- fill_start outside IDLE is ignored.
- rst asserted mid-access or mid-fill: all outputs return to reset values at that edge. sram_en is low from the next cycle. The partial fill is abandoned and fill_done does not pulse.
- rsp_rdata holds its value until the next read capture.

Test Plan:
- Reset: hold rst 2 cycles with req_valid=1 -> all outputs at reset values, sram_en never high, no acceptance.
- Write/read: ACC_CYCLES=2, write addr 10 data 100, then read addr 10 -> sram_en high exactly 2 cycles per access. rsp_valid at T+4 of the read with rsp_rdata=100. req_ready returns at T+5.
- Boundary addresses: write 0 -> 0x01 and 1023 -> 0xFF, read both -> 0x01, 0xFF. sram_addr stable throughout each en-high window.
- Back-to-back: req_valid held high for 3 reads (addrs 20, 40, 50) -> accepted at 5-cycle spacing, exactly 3 rsp_valid pulses, data in order.
- Fill: fill_start with fill_value=0xA5 and simultaneous req_valid -> fill wins, req_ready=0, busy=1. fill_done fires once after 1024*4+1023 cycles. Reads of 0, 512, 1023 return 0xA5. The pending request is accepted afterwards.
- Reset mid-fill: assert rst at addr 300 -> sram_en=0 next cycle, no fill_done. Location 299 = 0xA5, location 301 retains its old value.

Source files
------------

// File: rtl/sram_ctrl_if.sv
// Host-side request/response/fill signals plus the SRAM macro pins, bundled for sram_ctrl.
// slave is the controller's view; master is the view of whoever drives it.
interface sram_ctrl_if #(
    parameter int AW = 10,
    parameter int DW = 8
);
    logic          req_valid;
    logic          req_ready;
    logic          req_we;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic          rsp_valid;
    logic [DW-1:0] rsp_rdata;
    logic          fill_start;
    logic [DW-1:0] fill_value;
    logic          fill_done;
    logic          busy;
    logic          sram_en;
    logic          sram_rws;
    logic [AW-1:0] sram_addr;
    logic [DW-1:0] sram_din;
    logic [DW-1:0] sram_dout;

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, fill_start, fill_value, sram_dout,
        output req_ready, rsp_valid, rsp_rdata, fill_done, busy,
               sram_en, sram_rws, sram_addr, sram_din
    );

    modport master (
        output req_valid, req_we, req_addr, req_wdata, fill_start, fill_value, sram_dout,
        input  req_ready, rsp_valid, rsp_rdata, fill_done, busy,
               sram_en, sram_rws, sram_addr, sram_din
    );
endinterface

// File: rtl/sram_ctrl.sv
// Sequences single read/write requests and whole-array fills onto an async SRAM as setup/access/hold.
// One access per ACC_CYCLES+3 cycles; req_ready is low for the whole access or fill.
module sram_ctrl #(
    parameter int AW         = 10,
    parameter int DW         = 8,
    parameter int ACC_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    sram_ctrl_if.slave  bus
);
    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        ACCESS,
        HOLD,
        FILL_NEXT
    } state_e;

    localparam logic [AW-1:0] LAST_ADDR = '1;
    localparam logic [3:0]    CNT_INIT  = 4'(ACC_CYCLES - 1);

    state_e        state_q;
    logic [3:0]    cnt_q;
    logic          fill_q;
    logic          req_ready_q;
    logic          rsp_valid_q;
    logic [DW-1:0] rsp_rdata_q;
    logic          fill_done_q;
    logic          busy_q;
    logic          sram_en_q;
    logic          sram_rws_q;
    logic [AW-1:0] sram_addr_q;
    logic [DW-1:0] sram_din_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            fill_q      <= 1'b0;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            fill_done_q <= 1'b0;
            busy_q      <= 1'b0;
            sram_en_q   <= 1'b0;
            sram_rws_q  <= 1'b0;
            sram_addr_q <= '0;
            sram_din_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.fill_start) begin
                        fill_q      <= 1'b1;
                        sram_rws_q  <= 1'b1;
                        sram_addr_q <= '0;
                        sram_din_q  <= bus.fill_value;
                        req_ready_q <= 1'b0;
                        busy_q      <= 1'b1;
                        state_q     <= SETUP;
                    end else if (bus.req_valid && req_ready_q) begin
                        fill_q      <= 1'b0;
                        sram_rws_q  <= bus.req_we;
                        sram_addr_q <= bus.req_addr;
                        sram_din_q  <= bus.req_wdata;
                        req_ready_q <= 1'b0;
                        busy_q      <= 1'b1;
                        state_q     <= SETUP;
                    end
                end
                SETUP: begin
                    sram_en_q <= 1'b1;
                    cnt_q     <= CNT_INIT;
                    state_q   <= ACCESS;
                end
                ACCESS: begin
                    if (cnt_q == 4'd0) begin
                        // Outputs are registered, so the HOLD-cycle pulses are set on the way in.
                        sram_en_q <= 1'b0;
                        state_q   <= HOLD;
                        if (!sram_rws_q) begin
                            rsp_rdata_q <= bus.sram_dout;
                            rsp_valid_q <= 1'b1;
                        end
                        if (fill_q && sram_addr_q == LAST_ADDR) begin
                            fill_done_q <= 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                HOLD: begin
                    rsp_valid_q <= 1'b0;
                    fill_done_q <= 1'b0;
                    if (fill_q && sram_addr_q != LAST_ADDR) begin
                        sram_addr_q <= sram_addr_q + 1'b1;
                        state_q     <= FILL_NEXT;
                    end else begin
                        fill_q      <= 1'b0;
                        sram_rws_q  <= 1'b0;
                        req_ready_q <= 1'b1;
                        busy_q      <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                FILL_NEXT: begin
                    state_q <= SETUP;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.req_ready = req_ready_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.fill_done = fill_done_q;
    assign bus.busy      = busy_q;
    assign bus.sram_en   = sram_en_q;
    assign bus.sram_rws  = sram_rws_q;
    assign bus.sram_addr = sram_addr_q;
    assign bus.sram_din  = sram_din_q;
endmodule

// File: tb/tb_sram_ctrl.sv
// Bench for sram_ctrl against a behavioural 1024x8 SRAM: table of single accesses plus
// hand-written back-to-back, fill and reset-mid-fill sequences.
module tb_sram_ctrl;
    localparam int AW  = 10;
    localparam int DW  = 8;
    localparam int ACC = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    sram_ctrl_if #(.AW(AW), .DW(DW)) bus ();

    sram_ctrl #(.AW(AW), .DW(DW), .ACC_CYCLES(ACC)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [DW-1:0] mem [1024];
    always @(posedge clk) if (bus.sram_en && bus.sram_rws) mem[bus.sram_addr] <= bus.sram_din;
    assign bus.sram_dout = mem[bus.sram_addr];

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Protocol watchers: enable pulse width, address stability under enable, fill_done count.
    int en_run = 0, len_viol = 0, addr_viol = 0, done_cnt = 0;
    logic prev_en = 1'b0;
    logic [AW-1:0] prev_addr = '0;
    always @(negedge clk) begin
        if (bus.sram_en) begin
            en_run++;
            if (prev_en && bus.sram_addr != prev_addr) addr_viol++;
        end else if (en_run != 0) begin
            if (en_run != ACC) len_viol++;
            en_run = 0;
        end
        prev_en   = bus.sram_en;
        prev_addr = bus.sram_addr;
        if (bus.fill_done) done_cnt++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [DW-1:0] exp;
    } vec_t;

    // Called one tick after an edge with the controller idle.
    task automatic do_access(input vec_t v);
        int en_cyc;
        en_cyc = 0;
        bus.req_we    = v.we;
        bus.req_addr  = v.addr;
        bus.req_wdata = v.wdata;
        bus.req_valid = 1'b1;
        check("ready_before", 32'(bus.req_ready), 32'd1);
        step();
        bus.req_valid = 1'b0;
        check("setup_en_low", 32'(bus.sram_en), 32'd0);
        check("setup_busy", 32'(bus.busy), 32'd1);
        for (int k = 0; k < ACC; k++) begin
            step();
            en_cyc += int'(bus.sram_en);
        end
        check("en_cycles", 32'(en_cyc), 32'(ACC));
        step();
        check("hold_en_low", 32'(bus.sram_en), 32'd0);
        check("hold_rsp_valid", 32'(bus.rsp_valid), 32'(!v.we));
        if (!v.we) check("hold_rdata", 32'(bus.rsp_rdata), 32'(v.exp));
        step();
        check("ready_after", 32'(bus.req_ready), 32'd1);
        check("idle_rws", 32'(bus.sram_rws), 32'd0);
        check("idle_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    endtask

    vec_t vecs[10];
    logic [DW-1:0] rsp_q[$];
    always @(negedge clk) if (bus.rsp_valid) rsp_q.push_back(bus.rsp_rdata);

    initial begin
        logic [AW-1:0] b2b_addr[3];
        logic [DW-1:0] b2b_exp[3];
        int acc_cyc[3];
        int idx, n, done0;
        logic ready_prev, got, ready_seen;

        vecs[0] = '{1'b1, 10'd10,   8'd100,  8'h00};
        vecs[1] = '{1'b0, 10'd10,   8'h00,   8'd100};
        vecs[2] = '{1'b1, 10'd0,    8'h01,   8'h00};
        vecs[3] = '{1'b1, 10'd1023, 8'hFF,   8'h00};
        vecs[4] = '{1'b0, 10'd0,    8'h00,   8'h01};
        vecs[5] = '{1'b0, 10'd1023, 8'h00,   8'hFF};
        vecs[6] = '{1'b1, 10'd20,   8'h21,   8'h00};
        vecs[7] = '{1'b1, 10'd40,   8'h42,   8'h00};
        vecs[8] = '{1'b1, 10'd50,   8'h53,   8'h00};
        vecs[9] = '{1'b0, 10'd40,   8'h00,   8'h42};
        b2b_addr = '{10'd20, 10'd40, 10'd50};
        b2b_exp  = '{8'h21, 8'h42, 8'h53};

        rst = 1'b1;
        bus.req_valid = 1'b1;
        bus.req_we = 1'b1;
        bus.req_addr = 10'd5;
        bus.req_wdata = 8'h77;
        bus.fill_start = 1'b0;
        bus.fill_value = '0;

        for (int i = 0; i < 2; i++) begin
            step();
            check("rst_req_ready", 32'(bus.req_ready), 32'd1);
            check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
            check("rst_rsp_rdata", 32'(bus.rsp_rdata), 32'd0);
            check("rst_fill_done", 32'(bus.fill_done), 32'd0);
            check("rst_busy", 32'(bus.busy), 32'd0);
            check("rst_sram_en", 32'(bus.sram_en), 32'd0);
            check("rst_sram_rws", 32'(bus.sram_rws), 32'd0);
            check("rst_sram_addr", 32'(bus.sram_addr), 32'd0);
            check("rst_sram_din", 32'(bus.sram_din), 32'd0);
        end
        rst = 1'b0;
        bus.req_valid = 1'b0;
        step();
        check("no_accept_in_reset", 32'(bus.busy), 32'd0);

        for (int i = 0; i < 10; i++) do_access(vecs[i]);

        // Back-to-back reads with req_valid held high.
        rsp_q.delete();
        idx = 0;
        ready_prev = bus.req_ready;
        bus.req_we = 1'b0;
        bus.req_addr = b2b_addr[0];
        bus.req_valid = 1'b1;
        for (int c = 0; c < 100 && idx < 3; c++) begin
            step();
            if (ready_prev) begin
                acc_cyc[idx] = cyc;
                idx++;
                if (idx < 3) bus.req_addr = b2b_addr[idx];
                else bus.req_valid = 1'b0;
            end
            ready_prev = bus.req_ready;
        end
        check("b2b_accepted", 32'(idx), 32'd3);
        repeat (8) step();
        check("b2b_rsp_count", 32'(rsp_q.size()), 32'd3);
        for (int i = 0; i < 3; i++) begin
            if (i < rsp_q.size()) check("b2b_rdata", 32'(rsp_q[i]), 32'(b2b_exp[i]));
            if (i > 0 && i < idx) check("b2b_spacing", 32'(acc_cyc[i] - acc_cyc[i-1]), 32'(ACC + 3));
        end

        // Fill with a simultaneous read request: fill must win, read goes afterwards.
        done0 = done_cnt;
        bus.fill_value = 8'hA5;
        bus.fill_start = 1'b1;
        bus.req_valid = 1'b1;
        bus.req_we = 1'b0;
        bus.req_addr = 10'd512;
        step();
        bus.fill_start = 1'b0;
        check("fill_req_ready", 32'(bus.req_ready), 32'd0);
        check("fill_busy", 32'(bus.busy), 32'd1);
        check("fill_rws", 32'(bus.sram_rws), 32'd1);
        check("fill_din", 32'(bus.sram_din), 32'hA5);
        n = 1;
        got = 1'b0;
        ready_seen = 1'b0;
        for (int c = 0; c < 6000; c++) begin
            if (bus.fill_done) begin
                got = 1'b1;
                break;
            end
            if (bus.req_ready) ready_seen = 1'b1;
            step();
            n++;
        end
        check("fill_done_seen", 32'(got), 32'd1);
        // Inclusive cycle count from SETUP of address 0 to the fill_done cycle.
        check("fill_duration", 32'(n), 32'(1024 * (ACC + 2) + 1023));
        check("fill_ready_low", 32'(ready_seen), 32'd0);
        step();
        check("post_fill_ready", 32'(bus.req_ready), 32'd1);
        step();
        bus.req_valid = 1'b0;
        check("pending_accepted", 32'(bus.busy), 32'd1);
        got = 1'b0;
        for (int c = 0; c < 20; c++) begin
            step();
            if (bus.rsp_valid) begin
                got = 1'b1;
                break;
            end
        end
        check("pending_rsp", 32'(got), 32'd1);
        check("pending_rdata_512", 32'(bus.rsp_rdata), 32'hA5);
        step();
        check("fill_done_once", 32'(done_cnt - done0), 32'd1);
        do_access('{1'b0, 10'd0,    8'h00, 8'hA5});
        do_access('{1'b0, 10'd1023, 8'h00, 8'hA5});

        // Reset in the middle of a fill.
        do_access('{1'b1, 10'd299, 8'h00, 8'h00});
        do_access('{1'b1, 10'd301, 8'h3C, 8'h00});
        done0 = done_cnt;
        bus.fill_start = 1'b1;
        step();
        bus.fill_start = 1'b0;
        got = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            if (bus.sram_addr == 10'd300) begin
                got = 1'b1;
                break;
            end
            step();
        end
        check("reached_addr_300", 32'(got), 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("midrst_en", 32'(bus.sram_en), 32'd0);
        check("midrst_busy", 32'(bus.busy), 32'd0);
        check("midrst_addr", 32'(bus.sram_addr), 32'd0);
        check("midrst_ready", 32'(bus.req_ready), 32'd1);
        repeat (5) step();
        check("midrst_en_later", 32'(bus.sram_en), 32'd0);
        check("midrst_no_done", 32'(done_cnt - done0), 32'd0);
        do_access('{1'b0, 10'd299, 8'h00, 8'hA5});
        do_access('{1'b0, 10'd301, 8'h00, 8'h3C});

        check("en_width_violations", 32'(len_viol), 32'd0);
        check("addr_change_under_en", 32'(addr_viol), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
